// File: rtl/mdu.sv
// Multiply/divide unit: accepts one mult/div per busy period and holds the result
// in pending registers until the fixed-latency countdown commits it to HI/LO.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic        MDUstart,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] MDUout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pendHi_q, pendHi_d;
  logic [31:0] pendLo_q, pendLo_d;
  logic        pendValid_q, pendValid_d;

  logic        isStartOp;
  logic        isDivOp;
  logic        idle;
  logic        startFire;
  logic        commit;
  logic        mtAllowed;

  logic signed [63:0] prodSigned;
  logic        [63:0] prodUnsigned;
  logic        [31:0] divisorSafe;
  logic signed [31:0] quotSigned;
  logic signed [31:0] remSigned;
  logic        [31:0] quotUnsigned;
  logic        [31:0] remUnsigned;

  assign isStartOp = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
  assign isDivOp   = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
  assign idle      = (cnt_q == 4'd0);
  assign startFire = MDUstart && isStartOp && idle && !req;
  assign commit    = (cnt_q == 4'd1);
  assign mtAllowed = idle && !req;

  assign busy = (MDUstart && isStartOp) || !idle;

  assign prodSigned   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prodUnsigned = {32'd0, A} * {32'd0, B};

  // A zero divisor is swapped for 1 so the arithmetic stays defined; the result
  // is discarded anyway because pendValid is not set for that case.
  assign divisorSafe  = (B == 32'd0) ? 32'd1 : B;
  assign quotSigned   = $signed(A) / $signed(divisorSafe);
  assign remSigned    = $signed(A) % $signed(divisorSafe);
  assign quotUnsigned = A / divisorSafe;
  assign remUnsigned  = A % divisorSafe;

  always_comb begin
    pendHi_d    = pendHi_q;
    pendLo_d    = pendLo_q;
    pendValid_d = pendValid_q;
    cnt_d       = cnt_q;
    if (startFire) begin
      pendValid_d = !(isDivOp && (B == 32'd0));
      cnt_d       = isDivOp ? DIV_LOAD : MULT_LOAD;
      unique case (MDUop)
        OP_MULT: begin
          pendHi_d = prodSigned[63:32];
          pendLo_d = prodSigned[31:0];
        end
        OP_MULTU: begin
          pendHi_d = prodUnsigned[63:32];
          pendLo_d = prodUnsigned[31:0];
        end
        OP_DIV: begin
          pendHi_d = remSigned;
          pendLo_d = quotSigned;
        end
        default: begin
          pendHi_d = remUnsigned;
          pendLo_d = quotUnsigned;
        end
      endcase
    end else if (!idle) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Commit and mt writes are mutually exclusive: mt is only allowed when idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && pendValid_q) begin
      hi_d = pendHi_q;
      lo_d = pendLo_q;
    end else if (mtAllowed && (MDUop == OP_MTHI)) begin
      hi_d = A;
    end else if (mtAllowed && (MDUop == OP_MTLO)) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      cnt_q       <= 4'd0;
      pendHi_q    <= 32'd0;
      pendLo_q    <= 32'd0;
      pendValid_q <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      pendHi_q    <= pendHi_d;
      pendLo_q    <= pendLo_d;
      pendValid_q <= pendValid_d;
    end
  end

  always_comb begin
    MDUout = 32'd0;
    if (MDUop == OP_MFHI) begin
      MDUout = hi_q;
    end else if (MDUop == OP_MFLO) begin
      MDUout = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a behavioural HI/LO model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUop;
  logic        MDUstart;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] MDUout;

  int vectorCount = 0;
  int missCount   = 0;
  bit checkEnable = 1'b0;

  longint unsigned mHi, mLo, mPendHi, mPendLo;
  int  mRemain;
  bit  mPendValid;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUop(MDUop), .MDUstart(MDUstart),
    .A(A), .B(B), .req(req), .busy(busy), .MDUout(MDUout)
  );

  always #5 clk = ~clk;

  // Reference model: result computed at start, committed when the countdown expires.
  always @(posedge clk) begin
    longint sa, sb, q, r;
    longint unsigned p;
    if (reset) begin
      mHi = 0; mLo = 0; mPendHi = 0; mPendLo = 0; mRemain = 0; mPendValid = 0;
    end else if (mRemain != 0) begin
      mRemain = mRemain - 1;
      if (mRemain == 0 && mPendValid) begin
        mHi = mPendHi;
        mLo = mPendLo;
      end
    end else if (!req && MDUstart && MDUop >= 1 && MDUop <= 4) begin
      sa = longint'($signed(A));
      sb = longint'($signed(B));
      mPendValid = 1;
      case (MDUop)
        4'd1: begin p = sa * sb; mPendHi = p[63:32]; mPendLo = p[31:0]; end
        4'd2: begin p = longint'(A) * longint'(B); mPendHi = p[63:32]; mPendLo = p[31:0]; end
        4'd3: begin
          if (B == 0) mPendValid = 0;
          else begin
            q = sa / sb; r = sa - q * sb;
            mPendHi = r & 64'hFFFF_FFFF; mPendLo = q & 64'hFFFF_FFFF;
          end
        end
        default: begin
          if (B == 0) mPendValid = 0;
          else begin mPendHi = A % B; mPendLo = A / B; end
        end
      endcase
      mRemain = (MDUop <= 2) ? 5 : 10;
    end else if (!req && MDUop == 4'd7) begin
      mHi = A;
    end else if (!req && MDUop == 4'd8) begin
      mLo = A;
    end
  end

  // Single compare process, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    logic        expBusy;
    logic [31:0] expOut;
    #2;
    if (checkEnable) begin
      expBusy = (MDUstart && MDUop >= 1 && MDUop <= 4) || (mRemain != 0);
      expOut  = (MDUop == 5) ? mHi[31:0] : (MDUop == 6) ? mLo[31:0] : 32'd0;
      vectorCount++;
      if (busy !== expBusy || MDUout !== expOut) begin
        missCount++;
        $display("[TB] FAIL model_cmp t=%0t op=%0d: busy=%b out=%h, expected busy=%b out=%h",
                 $time, MDUop, busy, MDUout, expBusy, expOut);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic st, input logic [31:0] a,
                               input logic [31:0] b, input logic rq, input logic rst);
    @(negedge clk);
    MDUop = op; MDUstart = st; A = a; B = b; req = rq; reset = rst;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n, input logic expBusy, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #3 checkOutput(name, {31'd0, busy}, {31'd0, expBusy});
    end
  endtask

  task automatic readHiLo(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(4'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3 checkOutput({name, "_hi"}, MDUout, expHi);
    applyStimulus(4'd6, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3 checkOutput({name, "_lo"}, MDUout, expLo);
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input string name);
    applyStimulus(op, 1'b1, a, b, 1'b0, 1'b0);
    #3 checkOutput({name, "_busy_start"}, {31'd0, busy}, 32'd1);
    idleCycles(n, 1'b1, {name, "_busy_run"});
  endtask

  initial begin
    MDUop = 0; MDUstart = 0; A = 0; B = 0; req = 0; reset = 1;
    @(posedge clk);
    checkEnable = 1'b1;
    applyStimulus(4'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(4'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3 checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_out", MDUout, 32'd0);

    runOp(4'd1, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    readHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp(4'd2, 32'hFFFF_FFFF, 32'd2, 5, "multu");
    idleCycles(1, 1'b0, "multu_done");
    readHiLo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    runOp(4'd3, 32'hFFFF_FFF9, 32'd2, 10, "div");
    idleCycles(1, 1'b0, "div_done");
    readHiLo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp(4'd4, 32'd7, 32'd2, 10, "divu");
    readHiLo("divu", 32'd1, 32'd3);

    applyStimulus(4'd7, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd8, 1'b0, 32'h5678, 32'd0, 1'b0, 1'b0);
    runOp(4'd3, 32'd9, 32'd0, 10, "divzero");
    idleCycles(1, 1'b0, "divzero_done");
    readHiLo("divzero", 32'h1234, 32'h5678);

    applyStimulus(4'd1, 1'b1, 32'd5, 32'd5, 1'b1, 1'b0);
    #3 checkOutput("flush_busy_comb", {31'd0, busy}, 32'd1);
    idleCycles(1, 1'b0, "flush_no_cnt");
    applyStimulus(4'd8, 1'b0, 32'hAAAA, 32'd0, 1'b1, 1'b0);
    readHiLo("flush", 32'h1234, 32'h5678);

    runOp(4'd3, 32'd100, 32'd7, 6, "rstmid");
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(4'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #3 checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_hi", MDUout, 32'd0);
    idleCycles(6, 1'b0, "rstmid_quiet");
    readHiLo("rstmid_late", 32'd0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      applyStimulus(op, 1'($urandom_range(0, 3) != 0), a, b,
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) == 0));
    end
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
